// File: rtl/cpu_nbit_pkg.sv
// ---------------------------------------------------------------------------
// custom_types -- shared types for the cpu_nbit core.
//   opcode_t        : instruction opcodes (10..14 are undefined/illegal)
//   cpu_state_t     : control FSM states
//   alu_operation_t : operation selector for cpu_alu
// Helper functions classify a raw 4-bit opcode field.
// ---------------------------------------------------------------------------
package custom_types;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_MOV  = 4'd7,
        OP_JMP  = 4'd8,
        OP_JZ   = 4'd9,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } cpu_state_t;

    typedef enum logic [2:0] {
        ALU_PASS_IMM,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASS_B
    } alu_operation_t;

    // Map an opcode field onto the ALU operation that produces its result.
    function automatic alu_operation_t alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_MOV:  return ALU_PASS_B;
            default: return ALU_PASS_IMM;
        endcase
    endfunction

    // LDI, the five ALU ops and MOV need a WRITEBACK cycle.
    function automatic logic writes_reg(input logic [3:0] op);
        return (op >= OP_LDI) && (op <= OP_MOV);
    endfunction

    // Only the true ALU ops update the zero flag.
    function automatic logic sets_zero(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/cpu_nbit_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu -- combinational ALU, all results modulo 2^DATA_W.
//   op     : in  alu_operation_t  operation select
//   a, b   : in  DATA_W           operand registers A and B
//   imm    : in  DATA_W           immediate field (used by LDI)
//   result : out DATA_W           operation result
// ---------------------------------------------------------------------------
module cpu_alu
    import custom_types::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_operation_t     op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  imm,
    output logic [DATA_W-1:0]  result
);

    // NOTE: assign a default before the case so no path leaves result
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        result = imm;
        case (op)
            ALU_ADD:    result = a + b;   // carry discarded by width
            ALU_SUB:    result = a - b;   // borrow discarded by width
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_PASS_B: result = b;
            default:    result = imm;
        endcase
    end

endmodule

// File: rtl/cpu_nbit.sv
// ---------------------------------------------------------------------------
// cpu_nbit -- multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK core.
//   clk, reset       : in  clock, synchronous active-high reset
//   instruction      : in  INSTR_W {opcode, rd, rs, imm}
//   instr_valid      : in  instruction valid for instruction_addr
//   instr_req        : out core is in FETCH and wants an instruction
//   instruction_addr : out IADDR_W program counter
//   zero             : out zero flag
//   halted           : out core is in HALT
//   illegal          : out one-cycle pulse on an undefined opcode
//   dbg_we/idx/data  : out register-file write port mirror
// ---------------------------------------------------------------------------
module cpu_nbit
    import custom_types::*;
#(
    parameter int DATA_W  = 8,
    parameter int IADDR_W = 8,
    parameter int NREGS   = 4,
    localparam int RIDX_W  = $clog2(NREGS),
    localparam int INSTR_W = 4 + 2*RIDX_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    output logic               instr_req,
    output logic [IADDR_W-1:0] instruction_addr,
    output logic               zero,
    output logic               halted,
    output logic               illegal,
    output logic               dbg_we,
    output logic [RIDX_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0]  dbg_data
);

    cpu_state_t          state, state_next;
    logic [IADDR_W-1:0]  pc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   a, b, result_q, alu_result;
    logic [DATA_W-1:0]   regs [NREGS];

    // Instruction fields, MSB first.
    logic [3:0]          op;
    logic [RIDX_W-1:0]   rd, rs;
    logic [DATA_W-1:0]   imm;
    logic                jump_taken;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rd  = ir[INSTR_W-5 -: RIDX_W];
    assign rs  = ir[DATA_W +: RIDX_W];
    assign imm = ir[DATA_W-1:0];

    // JZ looks at the flag as it stands entering EXECUTE; JZ itself never
    // modifies zero, so there is no same-cycle hazard.
    assign jump_taken = (op == OP_JMP) || ((op == OP_JZ) && zero);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op_of(op)),
        .a      (a),
        .b      (b),
        .imm    (imm),
        .result (alu_result)
    );

    // ---- FSM: state register ----
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (instr_valid) state_next = S_DECODE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (op == OP_HALT)      state_next = S_HALT;
                else if (writes_reg(op)) state_next = S_WRITEBACK;
                else                    state_next = S_FETCH;
            end
            S_WRITEBACK: state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        instr_req = (state == S_FETCH);
        halted    = (state == S_HALT);
        illegal   = (state == S_EXECUTE) && is_illegal(op);
        dbg_we    = (state == S_WRITEBACK);
        dbg_idx   = rd;
        dbg_data  = result_q;
    end

    assign instruction_addr = pc;

    // ---- Datapath: PC, IR, operands, flag, register file ----
    // Reset has priority, so a reset landing on WRITEBACK drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            result_q <= '0;
            zero     <= 1'b0;
            // NOTE: the register file is architecturally zero after reset,
            // so it is built from resettable flops rather than a RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir <= instruction;
                        pc <= pc + IADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    a <= regs[rd];
                    b <= regs[rs];
                end
                S_EXECUTE: begin
                    result_q <= alu_result;
                    if (sets_zero(op)) zero <= (alu_result == '0);
                    if (jump_taken)    pc   <= imm[IADDR_W-1:0];
                end
                S_WRITEBACK: regs[rd] <= result_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_nbit.sv
// ---------------------------------------------------------------------------
// tb_cpu_nbit -- directed + randomized bench for cpu_nbit (8/8/4).
// The bench plays instruction memory one instruction at a time and keeps an
// architectural model (register array, PC, zero flag) that executes each
// instruction the moment it is handed over.
// ---------------------------------------------------------------------------
module tb_cpu_nbit;

    localparam int DATA_W  = 8;
    localparam int IADDR_W = 8;
    localparam int NREGS   = 4;
    localparam int RIDX_W  = 2;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               instr_req;
    logic [IADDR_W-1:0] instruction_addr;
    logic               zero;
    logic               halted;
    logic               illegal;
    logic               dbg_we;
    logic [RIDX_W-1:0]  dbg_idx;
    logic [DATA_W-1:0]  dbg_data;

    cpu_nbit #(.DATA_W(DATA_W), .IADDR_W(IADDR_W), .NREGS(NREGS)) dut (
        .clk              (clk),
        .reset            (reset),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .instr_req        (instr_req),
        .instruction_addr (instruction_addr),
        .zero             (zero),
        .halted           (halted),
        .illegal          (illegal),
        .dbg_we           (dbg_we),
        .dbg_idx          (dbg_idx),
        .dbg_data         (dbg_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Architectural model.
    int m_regs [NREGS];
    int m_pc;
    bit m_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_pc   = 0;
        m_zero = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rst_req",     instr_req, 1);
        check("rst_addr",    instruction_addr, 0);
        check("rst_zero",    zero, 0);
        check("rst_halted",  halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_dbg_we",  dbg_we, 0);
    endtask

    // Hand one instruction to the core (called at a negedge while in FETCH),
    // then follow it back to the next FETCH. Expected behaviour comes from
    // the model executing the instruction architecturally.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [7:0] imm,
                             input int stall);
        int  ra, rb, d, next_pc, exp_cycles, cycles, n_we, n_ill;
        bit  w, ill;
        logic [1:0] got_idx;
        logic [7:0] got_data;

        check("fetch_req",  instr_req, 1);
        check("fetch_addr", instruction_addr, m_pc);
        check("fetch_zero", zero, m_zero);

        ra = m_regs[rd];
        rb = m_regs[rs];
        d = 0; w = 0; ill = 0;
        next_pc = (m_pc + 1) % 256;
        case (op)
            4'd1: begin w = 1; d = imm; end
            4'd2: begin w = 1; d = (ra + rb) % 256;       m_zero = (d == 0); end
            4'd3: begin w = 1; d = (ra - rb + 256) % 256; m_zero = (d == 0); end
            4'd4: begin w = 1; d = ra & rb;               m_zero = (d == 0); end
            4'd5: begin w = 1; d = ra | rb;               m_zero = (d == 0); end
            4'd6: begin w = 1; d = ra ^ rb;               m_zero = (d == 0); end
            4'd7: begin w = 1; d = rb; end
            4'd8: next_pc = imm;
            4'd9: if (m_zero) next_pc = imm;
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14: ill = 1;
            default: ;
        endcase
        exp_cycles = w ? 4 : 3;

        for (int s = 0; s < stall; s++) begin
            instr_valid = 1'b0;
            @(negedge clk);
            check("stall_req",  instr_req, 1);
            check("stall_addr", instruction_addr, m_pc);
        end

        instruction = {op, rd, rs, imm};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;

        cycles = 1; n_we = 0; n_ill = 0; got_idx = '0; got_data = '0;
        while (instr_req !== 1'b1 && cycles < 10) begin
            if (dbg_we === 1'b1) begin
                n_we++;
                got_idx  = dbg_idx;
                got_data = dbg_data;
            end
            if (illegal === 1'b1) n_ill++;
            @(negedge clk);
            cycles++;
        end

        check("instr_cycles", cycles, exp_cycles);
        check("dbg_we_count", n_we, w ? 1 : 0);
        check("illegal_count", n_ill, ill ? 1 : 0);
        if (w) begin
            check("dbg_idx",  got_idx, rd);
            check("dbg_data", got_data, d);
            m_regs[rd] = d;
        end
        m_pc = next_pc;
    endtask

    initial begin
        int halt_bad;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        model_reset();
        do_reset();

        // Wrap on ADD sets zero.
        run_instr(4'd1, 2'd1, 2'd0, 8'h0F, 0);
        run_instr(4'd1, 2'd2, 2'd0, 8'hF1, 0);
        run_instr(4'd2, 2'd1, 2'd2, 8'h00, 0);
        // Taken JZ.
        run_instr(4'd9, 2'd0, 2'd0, 8'h20, 0);

        // SUB borrow, zero clear, JZ not taken.
        run_instr(4'd1, 2'd0, 2'd0, 8'h05, 0);
        run_instr(4'd1, 2'd1, 2'd0, 8'h07, 0);
        run_instr(4'd3, 2'd0, 2'd1, 8'h00, 0);
        run_instr(4'd9, 2'd0, 2'd0, 8'h20, 0);

        // PC wrap: NOP at 0xFF, then JMP from 0xFF.
        run_instr(4'd8, 2'd0, 2'd0, 8'hFF, 0);
        run_instr(4'd0, 2'd0, 2'd0, 8'h00, 0);
        run_instr(4'd8, 2'd0, 2'd0, 8'hFF, 0);
        run_instr(4'd8, 2'd0, 2'd0, 8'h10, 0);

        // Five-cycle fetch stall, then MOV to confirm registers intact.
        run_instr(4'd0, 2'd0, 2'd0, 8'h00, 5);
        run_instr(4'd7, 2'd3, 2'd0, 8'h00, 0);

        // Illegal opcode.
        run_instr(4'hA, 2'd2, 2'd1, 8'h33, 0);

        // Randomized instruction stream (no HALT).
        for (int k = 0; k < 60; k++) begin
            run_instr(4'($urandom_range(14, 0)), 2'($urandom_range(3, 0)),
                      2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)),
                      int'($urandom_range(2, 0)));
        end

        // Reset during WRITEBACK of LDI r3,0x55 aborts the write.
        do_reset();
        instruction = {4'd1, 2'd3, 2'd0, 8'h55};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wb_before_reset", dbg_we, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("abort_addr", instruction_addr, 0);
        check("abort_req",  instr_req, 1);
        check("abort_we",   dbg_we, 0);
        run_instr(4'd7, 2'd0, 2'd3, 8'h00, 0);

        // HALT holds for 20+ cycles until reset.
        run_instr(4'd1, 2'd2, 2'd0, 8'h9C, 0);
        instruction = {4'hF, 2'd0, 2'd0, 8'h00};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        halt_bad = 0;
        for (int c = 0; c < 24; c++) begin
            if (halted !== 1'b1 || instr_req !== 1'b0 || dbg_we !== 1'b0) halt_bad++;
            @(negedge clk);
        end
        check("halt_hold", halt_bad, 0);
        check("halt_addr", instruction_addr, (m_pc + 1) % 256);
        instr_valid = 1'b0;
        do_reset();
        run_instr(4'd7, 2'd1, 2'd2, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
